// File: rtl/player_input_mapper_if.sv
// Player-input bus between hps_io-side stimulus and player_input_mapper.
// The master drives keyboard, joystick, key-map and autofire inputs; the slave returns the player word.
interface player_input_mapper_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned NUM_BITS    = 16
);
    logic [10:0]                       ps2_key;
    logic [NUM_PLAYERS*NUM_BITS-1:0]   joystick;
    logic                              map_wr;
    logic [8:0]                        map_addr;
    logic [6:0]                        map_data;
    logic [NUM_PLAYERS*NUM_BITS-1:0]   autofire_mask;
    logic [NUM_PLAYERS*NUM_BITS-1:0]   player;

    modport master (
        output ps2_key, joystick, map_wr, map_addr, map_data, autofire_mask,
        input  player
    );

    modport slave (
        input  ps2_key, joystick, map_wr, map_addr, map_data, autofire_mask,
        output player
    );
endinterface

// File: rtl/player_input_mapper.sv
// Programmable PS/2 key map merged with joysticks, coin pulse stretching and optional autofire.
// Autofire logic is built only when PLAYER_INPUT_AUTOFIRE_EN is defined.
module player_input_mapper #(
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned NUM_BITS          = 16,
    parameter int unsigned COIN_BIT          = 8,
    parameter int unsigned COIN_PULSE_CYCLES = 1024,
    parameter int unsigned AUTOFIRE_HALF     = 65536
) (
    input  logic                  clock,
    input  logic                  reset_n,
    player_input_mapper_if.slave  bus
);

    localparam int unsigned CW = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;

    typedef logic [NUM_PLAYERS-1:0][NUM_BITS-1:0] word_t;

    logic        toggle_q;
    logic        s1_ev;
    logic        s1_pressed;
    logic [8:0]  s1_idx;
    logic        s2_ev;
    logic        s2_pressed;
    logic [6:0]  map_q;
    logic [6:0]  map_ram [0:511];
    logic [1:0]  s2_player;
    logic [3:0]  s2_bit;
    logic        s2_hit;

    word_t key_state;
    word_t joy_q;
    word_t merged;
    word_t stretched;
    word_t gated;
    word_t player_q;

    // S0 detects a strobe toggle; S1 carries the event alongside the map read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q   <= 1'b0;
            s1_ev      <= 1'b0;
            s1_pressed <= 1'b0;
            s1_idx     <= '0;
            s2_ev      <= 1'b0;
            s2_pressed <= 1'b0;
        end else begin
            toggle_q   <= bus.ps2_key[10];
            s1_ev      <= bus.ps2_key[10] != toggle_q;
            s1_pressed <= bus.ps2_key[9];
            s1_idx     <= bus.ps2_key[8:0];
            s2_ev      <= s1_ev;
            s2_pressed <= s1_pressed;
        end
    end

    // Read and write share one edge, so a same-index write returns the old entry.
    always_ff @(posedge clock) begin
        if (bus.map_wr) begin
            map_ram[bus.map_addr] <= bus.map_data;
        end
        map_q <= map_ram[s1_idx];
    end

    assign s2_player = map_q[5:4];
    assign s2_bit    = map_q[3:0];
    assign s2_hit    = s2_ev & map_q[6]
                     & (32'(s2_player) < NUM_PLAYERS)
                     & (32'(s2_bit) < NUM_BITS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_state <= '0;
        end else if (s2_hit) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                for (int unsigned b = 0; b < NUM_BITS; b++) begin
                    if (32'(s2_player) == p && 32'(s2_bit) == b) begin
                        key_state[p][b] <= s2_pressed;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            joy_q <= '0;
        end else begin
            joy_q <= bus.joystick;
        end
    end

    assign merged = key_state | joy_q;

    // A rising coin edge (re)loads the counter; the output holds while merged coin or counter is nonzero.
    if (COIN_BIT < NUM_BITS) begin : g_coin
        logic [NUM_PLAYERS-1:0] coin_out;

        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
            logic [CW-1:0] cnt;
            logic          prev;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt  <= '0;
                    prev <= 1'b0;
                end else begin
                    prev <= merged[p][COIN_BIT];
                    if (merged[p][COIN_BIT] && !prev) begin
                        cnt <= CW'(COIN_PULSE_CYCLES - 1);
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end

            assign coin_out[p] = merged[p][COIN_BIT] | (cnt != '0);
        end

        always_comb begin
            stretched = merged;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                stretched[p][COIN_BIT] = coin_out[p];
            end
        end
    end else begin : g_no_coin
        assign stretched = merged;
    end

`ifdef PLAYER_INPUT_AUTOFIRE_EN
    localparam int unsigned AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

    logic [AW-1:0] af_cnt;
    logic          phase;
    word_t         af_mask;

    assign af_mask = bus.autofire_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt <= '0;
            phase  <= 1'b0;
        end else if (af_cnt == AW'(AUTOFIRE_HALF - 1)) begin
            af_cnt <= '0;
            phase  <= ~phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end

    // The coin bit is never gated so a held coin button still registers.
    always_comb begin
        gated = stretched;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            for (int unsigned b = 0; b < NUM_BITS; b++) begin
                if (af_mask[p][b] && b != COIN_BIT) begin
                    gated[p][b] = stretched[p][b] & phase;
                end
            end
        end
    end
`else
    logic unused_autofire_mask;

    assign unused_autofire_mask = ^bus.autofire_mask;
    assign gated                = stretched;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            player_q <= '0;
        end else begin
            player_q <= gated;
        end
    end

    assign bus.player = player_q;

endmodule

// File: tb/tb_player_input_mapper.sv
// Directed bench for player_input_mapper: key map latency, ext codes, back-to-back events,
// coin stretching, read-during-write, autofire gating and reset mid-operation.
module tb_player_input_mapper;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic tog     = 1'b0;
    logic samples [24];
    int   ones;

    always #5 clk_sys = ~clk_sys;

    player_input_mapper_if #(.NUM_PLAYERS(2), .NUM_BITS(16)) bus ();

    player_input_mapper #(
        .NUM_PLAYERS      (2),
        .NUM_BITS         (16),
        .COIN_BIT         (8),
        .COIN_PULSE_CYCLES(8),
        .AUTOFIRE_HALF    (4)
    ) dut (
        .clock  (clk_sys),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_map(input logic [8:0] addr, input logic [6:0] data);
        bus.map_wr   = 1'b1;
        bus.map_addr = addr;
        bus.map_data = data;
        tick();
        bus.map_wr   = 1'b0;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog         = ~tog;
        bus.ps2_key = {tog, pressed, ext, code};
    endtask

    initial begin
        bus.ps2_key       = '0;
        bus.joystick      = '0;
        bus.map_wr        = 1'b0;
        bus.map_addr      = '0;
        bus.map_data      = '0;
        bus.autofire_mask = '0;
        tick(3);
        chk("reset_player", bus.player, 32'h0);
        reset_n = 1'b1;
        tick();

        wr_map(9'h075, 7'b1000011);
        wr_map(9'h174, 7'b1010000);
        wr_map(9'h074, 7'b0000000);
        wr_map(9'h010, 7'b1000100);
        wr_map(9'h011, 7'b1000101);
        wr_map(9'h012, 7'b1010100);
        wr_map(9'h020, 7'b0000000);
        tick(2);
        chk("idle_after_map", bus.player, 32'h0);

        send_key(1'b1, 1'b0, 8'h75);
        tick(3);
        chk("press_lat3", bus.player, 32'h0);
        tick();
        chk("press_lat4", bus.player, 32'h0000_0008);
        tick(2);
        send_key(1'b0, 1'b0, 8'h75);
        tick(4);
        chk("release", bus.player, 32'h0);

        send_key(1'b1, 1'b0, 8'h74);
        tick(6);
        chk("ext0_nochange", bus.player, 32'h0);
        send_key(1'b1, 1'b1, 8'h74);
        tick(4);
        chk("ext1_p1b0", bus.player, 32'h0001_0000);
        send_key(1'b0, 1'b1, 8'h74);
        tick(4);
        chk("ext1_release", bus.player, 32'h0);

        send_key(1'b1, 1'b0, 8'h10);
        tick();
        send_key(1'b1, 1'b0, 8'h11);
        tick();
        send_key(1'b1, 1'b0, 8'h12);
        tick(2);
        chk("b2b_first", bus.player, 32'h0000_0010);
        tick();
        chk("b2b_second", bus.player, 32'h0000_0030);
        tick();
        chk("b2b_third", bus.player, 32'h0010_0030);
        send_key(1'b0, 1'b0, 8'h10);
        tick();
        send_key(1'b0, 1'b0, 8'h11);
        tick();
        send_key(1'b0, 1'b0, 8'h12);
        tick(4);
        chk("b2b_release", bus.player, 32'h0);

        // single coin pulse: high on ticks 2..9
        for (int t = 0; t < 12; t++) begin
            bus.joystick[8] = (t == 0);
            tick();
            chk("coin_single", {31'b0, bus.player[8]}, {31'b0, (t + 1 >= 2) && (t + 1 <= 9)});
        end
        tick(2);
        // second pulse four cycles later extends the output to tick 13
        for (int t = 0; t < 16; t++) begin
            bus.joystick[8] = (t == 0) || (t == 4);
            tick();
            chk("coin_retrig", {31'b0, bus.player[8]}, {31'b0, (t + 1 >= 2) && (t + 1 <= 13)});
        end
        tick(2);

        // map write lands on the same edge as the event's map read
        send_key(1'b1, 1'b0, 8'h20);
        tick();
        bus.map_wr   = 1'b1;
        bus.map_addr = 9'h020;
        bus.map_data = 7'b1000111;
        tick();
        bus.map_wr   = 1'b0;
        tick(2);
        chk("rdw_dropped", bus.player, 32'h0);
        send_key(1'b1, 1'b0, 8'h20);
        tick(4);
        chk("rdw_repeat", bus.player, 32'h0000_0080);

        bus.autofire_mask = 32'h0000_0010;
        send_key(1'b1, 1'b0, 8'h10);
        tick(6);
        for (int i = 0; i < 24; i++) begin
            samples[i] = bus.player[4];
            chk("af_other_bits", bus.player & ~32'h0000_0010, 32'h0000_0080);
            tick();
        end
`ifdef PLAYER_INPUT_AUTOFIRE_EN
        ones = 0;
        for (int i = 0; i < 24; i++) begin
            ones += int'(samples[i]);
            if (i >= 4) begin
                chk("af_square", {31'b0, samples[i]}, {31'b0, ~samples[i - 4]});
            end
        end
        chk("af_duty", 32'(ones), 32'd12);
`else
        ones = 0;
        for (int i = 0; i < 24; i++) begin
            ones += int'(samples[i]);
            chk("af_steady", {31'b0, samples[i]}, 32'h1);
        end
        chk("af_duty", 32'(ones), 32'd24);
`endif

        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", bus.player, 32'h0);
        bus.autofire_mask = '0;
        tog               = 1'b1;
        bus.ps2_key       = {1'b1, 1'b1, 1'b0, 8'h75};
        tick(2);
        chk("reset_hold", bus.player, 32'h0);
        reset_n = 1'b1;
        tick(3);
        chk("post_reset_lat3", bus.player, 32'h0);
        tick();
        chk("post_reset_event", bus.player, 32'h0000_0008);
        tick(4);
        chk("post_reset_single", bus.player, 32'h0000_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
